// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES controller ports at $4016/$4017.
// Optional turbo buttons are enabled with the JP_TURBO_EN macro.
package nes_jp_pkg;

  localparam logic [15:0] JP_ADDR_1P   = 16'h4016;
  localparam logic [15:0] JP_ADDR_2P   = 16'h4017;

  localparam int          BTN_A        = 0;
  localparam int          BTN_B        = 1;
  localparam int          BTN_SELECT   = 2;
  localparam int          BTN_START    = 3;
  localparam int          BTN_UP       = 4;
  localparam int          BTN_DOWN     = 5;
  localparam int          BTN_LEFT     = 6;
  localparam int          BTN_RIGHT    = 7;
  localparam int          BTN_TURBO_A  = 8;
  localparam int          BTN_TURBO_B  = 9;

  localparam int          JP_NUM_PORTS = 2;
  localparam logic [2:0]  JP_OPEN_BUS  = 3'b010;

  // Upper bits mimic the open-bus value the CPU sees on a real console.
  function automatic logic [7:0] jp_rdata(input logic serial_bit);
    return {JP_OPEN_BUS, 4'b0000, serial_bit};
  endfunction

endpackage

// File: rtl/jp_port.sv
// One controller port: input synchroniser, optional turbo merge and the
// 8-bit serial shift register. Turbo merge exists only with JP_TURBO_EN.
module jp_port
  import nes_jp_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       strobe,
  input  logic       rd,
  input  logic [9:0] jp_vec,
  input  logic       turbo_phase,
  output logic       sbit
);

  logic [9:0] sync1_reg;
  logic [9:0] sync_reg;
  logic [7:0] load_val;
  logic [7:0] sr_reg;
  logic [7:0] sr_next;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
    end else begin
      sync1_reg <= jp_vec;
      sync_reg  <= sync1_reg;
    end
  end

  always_comb begin
    load_val = sync_reg[7:0];
`ifdef JP_TURBO_EN
    load_val[BTN_A] = sync_reg[BTN_A] | (sync_reg[BTN_TURBO_A] & turbo_phase);
    load_val[BTN_B] = sync_reg[BTN_B] | (sync_reg[BTN_TURBO_B] & turbo_phase);
`endif
  end

  // Strobe wins over shifting; ones fill in from the top after 8 reads.
  always_comb begin
    sr_next = sr_reg;
    if (strobe)
      sr_next = load_val;
    else if (rd)
      sr_next = {1'b1, sr_reg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      sr_reg <= '0;
    else
      sr_reg <= sr_next;
  end

  assign sbit = sr_reg[0];

endmodule

// File: rtl/nes_joypad.sv
// CPU-bus responder for NES controller ports $4016/$4017 (serial strobe/shift).
// Define JP_TURBO_EN to add the turbo A/B phase counter.
module nes_joypad
  import nes_jp_pkg::*;
#(
  parameter logic [15:0] TURBO_PERIOD = 16'd29830
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic [7:0]  o_jpd_rdata,
  input  logic [9:0]  i_jp_vec_1p,
  input  logic [9:0]  i_jp_vec_2p
);

  logic       strobe_reg;
  logic       strobe_next;
  logic       rd_1p;
  logic       rd_2p;
  logic       turbo_phase;
  logic [9:0] jp_vec [JP_NUM_PORTS];
  logic       port_rd [JP_NUM_PORTS];
  logic       port_bit [JP_NUM_PORTS];

  assign rd_1p = (i_bus_addr == JP_ADDR_1P) && i_bus_wn;
  assign rd_2p = (i_bus_addr == JP_ADDR_2P) && i_bus_wn;

  // Ports load from the post-write strobe so a read right after the write
  // already sees the freshly latched buttons.
  always_comb begin
    strobe_next = strobe_reg;
    if ((i_bus_addr == JP_ADDR_1P) && !i_bus_wn)
      strobe_next = i_bus_wdata[0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      strobe_reg <= 1'b0;
    else
      strobe_reg <= strobe_next;
  end

`ifdef JP_TURBO_EN
  logic [15:0] turbo_cnt_reg;
  logic        turbo_phase_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      turbo_cnt_reg   <= '0;
      turbo_phase_reg <= 1'b0;
    end else if (turbo_cnt_reg == TURBO_PERIOD - 16'd1) begin
      turbo_cnt_reg   <= '0;
      turbo_phase_reg <= ~turbo_phase_reg;
    end else begin
      turbo_cnt_reg   <= turbo_cnt_reg + 16'd1;
    end
  end

  assign turbo_phase = turbo_phase_reg;
`else
  assign turbo_phase = 1'b0;
`endif

  assign jp_vec[0]  = i_jp_vec_1p;
  assign jp_vec[1]  = i_jp_vec_2p;
  assign port_rd[0] = rd_1p;
  assign port_rd[1] = rd_2p;

  generate
    for (genvar gi = 0; gi < JP_NUM_PORTS; gi++) begin : g_port
      jp_port u_port (
        .clk         (i_clk),
        .rstn        (i_rstn),
        .strobe      (strobe_next),
        .rd          (port_rd[gi]),
        .jp_vec      (jp_vec[gi]),
        .turbo_phase (turbo_phase),
        .sbit        (port_bit[gi])
      );
    end
  endgenerate

  always_comb begin
    o_jpd_rdata = 8'h00;
    if (rd_1p)
      o_jpd_rdata = jp_rdata(port_bit[0]);
    else if (rd_2p)
      o_jpd_rdata = jp_rdata(port_bit[1]);
  end

endmodule

// File: tb/tb_nes_joypad.sv
// Scoreboard bench for nes_joypad: expected read data is queued when a read
// is driven and compared when the bus is sampled on the falling edge.
module tb_nes_joypad;

  logic        clk;
  logic        rstn;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [7:0]  jpd_rdata;
  logic [9:0]  jp_vec_1p;
  logic [9:0]  jp_vec_2p;

  int          checks;
  int          errors;
  logic [15:0] exp_q [$];

  nes_joypad #(.TURBO_PERIOD(16'd4)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .o_jpd_rdata (jpd_rdata),
    .i_jp_vec_1p (jp_vec_1p),
    .i_jp_vec_2p (jp_vec_2p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s got %h", tag, got);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus_addr  = addr;
    bus_wn    = 1'b0;
    bus_wdata = data;
    @(posedge clk);
    #1;
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
  endtask

  // One read cycle; returns the sampled data for callers that need it.
  task automatic bus_read(input string tag, input logic [15:0] addr,
                          input logic [7:0] exp, output logic [7:0] got);
    exp_q.push_back({8'h00, exp});
    bus_addr = addr;
    bus_wn   = 1'b1;
    @(negedge clk);
    got = jpd_rdata;
    if (exp_q.size() == 0)
      check({tag, "_underflow"}, 16'hdead, 16'h0000);
    else
      check(tag, {8'h00, got}, exp_q.pop_front());
    @(posedge clk);
    #1;
    bus_addr = 16'h0000;
  endtask

  logic [7:0] rd_val;
  logic [7:0] seq_exp [10];
  logic       a_pat [12];
  logic       a_hist [$];

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
    jp_vec_1p = 10'h000;
    jp_vec_2p = 10'h000;
    idle_cycles(3);
    rstn = 1'b1;
    idle_cycles(1);

    // Reset state: both ports read zero bits with open-bus upper bits.
    bus_read("rst_4016", 16'h4016, 8'h40, rd_val);
    bus_read("rst_4017", 16'h4017, 8'h40, rd_val);
    bus_read("rst_0000", 16'h0000, 8'h00, rd_val);

    // A + Start, full serial sequence plus trailing ones.
    jp_vec_1p = 10'h009;
    idle_cycles(3);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    seq_exp = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    for (int i = 0; i < 10; i++)
      bus_read($sformatf("seq_%0d", i), 16'h4016, seq_exp[i], rd_val);

    // Strobe held: reads follow A with three cycles of lag, never shift.
    jp_vec_1p = 10'h000;
    idle_cycles(3);
    bus_write(16'h4016, 8'h01);
    a_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a_hist = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      jp_vec_1p = {9'b0, a_pat[k]};
      a_hist.push_back(a_pat[k]);
      bus_read($sformatf("strb_%0d", k), 16'h4016, {7'b0100000, a_hist.pop_front()}, rd_val);
    end
    bus_write(16'h4016, 8'h00);

    // Interleaved ports: Right on 1p, Up on 2p.
    jp_vec_1p = 10'h080;
    jp_vec_2p = 10'h010;
    idle_cycles(3);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 5; i++)
      bus_read($sformatf("p2_%0d", i), 16'h4017, (i == 4) ? 8'h41 : 8'h40, rd_val);
    for (int i = 0; i < 8; i++)
      bus_read($sformatf("p1_%0d", i), 16'h4016, (i == 7) ? 8'h41 : 8'h40, rd_val);

    // Turbo A only.
    jp_vec_1p = 10'h100;
    jp_vec_2p = 10'h000;
    idle_cycles(3);
    bus_write(16'h4016, 8'h01);
`ifdef JP_TURBO_EN
    begin
      logic prev;
      int   run;
      int   runs;
      logic [7:0] got;
      runs = 0;
      run  = 0;
      prev = 1'b0;
      for (int i = 0; i < 26; i++) begin
        bus_addr = 16'h4016;
        bus_wn   = 1'b1;
        @(negedge clk);
        got = jpd_rdata;
        if (i == 0) begin
          prev = got[0];
          run  = 1;
        end else if (got[0] == prev) begin
          run++;
        end else begin
          if (runs > 0) check($sformatf("turbo_run_%0d", runs), 16'(run), 16'd4);
          runs++;
          prev = got[0];
          run  = 1;
        end
        check($sformatf("turbo_hi_%0d", i), {8'h00, got[7:1], 1'b0}, 16'h0040);
        @(posedge clk);
        #1;
      end
      check("turbo_runs_seen", 16'(runs >= 4), 16'd1);
      bus_addr = 16'h0000;
    end
`else
    for (int i = 0; i < 12; i++)
      bus_read($sformatf("noturbo_%0d", i), 16'h4016, 8'h40, rd_val);
`endif
    bus_write(16'h4016, 8'h00);

    // Reset in the middle of a read sequence clears registers and strobe.
    jp_vec_1p = 10'h009;
    idle_cycles(3);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    bus_read("mid_0", 16'h4016, 8'h41, rd_val);
    bus_read("mid_1", 16'h4016, 8'h40, rd_val);
    bus_read("mid_2", 16'h4016, 8'h40, rd_val);
    rstn = 1'b0;
    idle_cycles(1);
    rstn = 1'b1;
    bus_read("post_rst_0", 16'h4016, 8'h40, rd_val);
    idle_cycles(3);
    bus_read("post_rst_1", 16'h4016, 8'h40, rd_val);
    bus_read("post_rst_2p", 16'h4017, 8'h40, rd_val);

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_joypad.md
# nes_joypad

CPU-bus responder for the two NES controller ports at $4016/$4017. Takes the board-side parallel button vectors and presents them to the CPU using the original serial strobe/shift protocol. A write to $4016 sets the strobe; each read of $4016 or $4017 returns one button bit and advances that port's shift register. Sits beside ram_2k_adpt and mmc on the nes_bus fabric, clocked by the CPU clock, and feeds the i_jpd_rdata input of nes_bus.

## Interface
- TURBO_PERIOD, 16'd29830: CPU clocks per turbo phase toggle; 1.79 MHz / (2 × 29830) ≈ 30 Hz. Used only with JP_TURBO_EN.
- i_clk  in  1  CPU clock.
- i_rstn  in  1  Reset: synchronous, active-low.
- i_bus_addr  in  16  Bus address.
- i_bus_wn  in  1  1 = read, 0 = write.
- i_bus_wdata  in  8  Bus write data.
- o_jpd_rdata  out  8  Read data.
- i_jp_vec_1p  in  10  Port 1 buttons, asynchronous, 1 = pressed. Bit order: [0]A, [1]B, [2]Select, [3]Start, [4]Up, [5]Down, [6]Left, [7]Right, [8]turbo A, [9]turbo B.
- i_jp_vec_2p  in  10  Port 2 buttons, same encoding as port 1.

## Operation
- Synchroniser:
  - Each input vector passes through a 2-flop synchroniser.
  - Logic uses only the synchronised values sync_1p and sync_2p.
- Strobe register:
  - Write with i_bus_addr == 16'h4016 and i_bus_wn == 0 sets strobe <= i_bus_wdata[0].
  - Writes to $4017 are ignored; that address belongs to the APU frame counter.
- Shift register: one 8-bit register per port.
  - While strobe == 1, every cycle loads {Right, Left, Down, Up, Start, Select, B, A} from the synced vector. Reads do not shift.
  - On the 1→0 strobe transition the last loaded value is held.
- Read decode: rd_1p = (addr == 16'h4016 && wn), rd_2p = (addr == 16'h4017 && wn).
- o_jpd_rdata (combinational):
  - rd_1p: {3'b010, 4'b0000, sr1[0]}.
  - rd_2p: {3'b010, 4'b0000, sr2[0]}.
  - Otherwise: 8'h00. nes_bus ORs or muxes the sources.
  - Bits [7:5] = 3'b010 emulate open bus.
- Shift: at the end of each cycle where rd_x is active and strobe == 0, sr_x <= {1'b1, sr_x[7:1]}.
  - After 8 reads, every further read returns 1, matching official controllers.
  - Reading one port never shifts the other.
- Strobe and read in the same cycle are impossible on a single bus. Strobe = 1 overrides shifting.
- No pending state survives across operations; a mid-sequence reset simply clears the registers.

## Timing
- Reset values: synchroniser flops 0, strobe 0, sr1 = sr2 = 8'h00, turbo counter 0, turbo phase 0.
- o_jpd_rdata reflects the current sr_x[0] in the same cycle as the read (zero latency). The shift takes effect at the clock edge ending the read cycle.
- Button press to shift-register visibility (strobe = 1): 3 clock edges. Two edges for the synchroniser, then one for the load.
- Strobe write takes effect at the write cycle's edge. A read in the next cycle sees the value loaded on that same edge.
- One shift per bus cycle. A read held for N cycles shifts N times; nes_bus does not present CPU addresses during DMA pause.

## Configuration
- JP_TURBO_EN defined:
  - A 16-bit counter counts 0..TURBO_PERIOD-1 and toggles turbo_phase on wrap.
  - The loaded A bit is A | (turboA & turbo_phase); the loaded B bit is B | (turboB & turbo_phase).
- Not defined:
  - Bits [9:8] are ignored.
  - No counter is instantiated, so there is no turbo logic.

## Structure
- Package nes_jp_pkg holds:
  - Constants JP_ADDR_1P = 16'h4016 and JP_ADDR_2P = 16'h4017.
  - Button bit index constants.
  - JP_OPEN_BUS = 3'b010.
- Sub-module jp_port, instantiated twice. It contains the synchroniser, the turbo OR, and the 8-bit shift register. Its inputs are strobe, rd, the raw vector and turbo_phase; its output is the serial bit.
- The shared strobe register, turbo counter and read mux live in nes_joypad.

## Test plan
- Reset, then read $4016 → 8'h40; read $4017 → 8'h40; read $0000 → 8'h00.
- 1p vector 10'h009 (A + Start). Write $4016 = 1, then 0. Eight reads of $4016 → 41, 40, 40, 41, 40, 40, 40, 40. Ninth and tenth reads → 41.
- Strobe held at 1 with 1p A toggled: every $4016 read tracks A, with a 3-cycle lag from the input change. No shifting occurs.
- Interleaving:
  - Setup: 1p = 10'h080 (Right), 2p = 10'h010 (Up), strobe pulsed.
  - Stimulus: read $4017 ×5, then $4016 ×8.
  - Expected: $4017 returns 40, 40, 40, 40, 41; $4016 returns 40 ×7, then 41.
- JP_TURBO_EN with TURBO_PERIOD = 4 and 1p = 10'h100: strobe held high; the $4016 read alternates 41 ×4 cycles / 40 ×4 cycles. Without the macro it stays at 40.
- Assert i_rstn low midway through the 8-read sequence: the next read → 8'h40, and the strobe is cleared.
